// File: rtl/axis_meta_skid.sv
// axis_meta_skid
// Two-entry skid buffer for a valid/ready meta-data stream, with
// transfer and stall statistics counters.
//
// meta_in_ready and meta_out_valid/meta_out_data come straight from flops.
// This breaks every combinational path between the upstream and downstream
// handshakes.
//
// The main register always holds the word at the head of the buffer.
// The skid register catches the one word accepted while the head is stalled.
module axis_meta_skid #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             meta_in_valid,
   output logic             meta_in_ready,
   input  logic [WIDTH-1:0] meta_in_data,
   output logic             meta_out_valid,
   input  logic             meta_out_ready,
   output logic [WIDTH-1:0] meta_out_data,
   input  logic             clear_stats,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] xfer_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] xfer_q, xfer_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             in_fire;
   logic             out_fire;

   assign in_fire  = meta_in_valid & in_ready_q;
   assign out_fire = out_valid_q & meta_out_ready;

   // Next state and data movement.
   // Ready and valid are precomputed from the next state so they can live in flops.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               main_d  = meta_in_data;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (in_fire && out_fire) begin
               main_d = meta_in_data;
            end else if (in_fire) begin
               skid_d  = meta_in_data;
               state_d = ST_FULL;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_fire) begin
               main_d  = skid_q;
               state_d = ST_BUSY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      in_ready_d  = (state_d != ST_FULL);
      out_valid_d = (state_d != ST_EMPTY);
   end

   // Statistics: clear wins over any increment.
   // The stall counter sticks at all-ones.
   always_comb begin
      xfer_d  = xfer_q;
      stall_d = stall_q;
      if (clear_stats) begin
         xfer_d  = '0;
         stall_d = '0;
      end else begin
         if (out_fire) begin
            xfer_d = xfer_q + CNT_ONE;
         end
         if (out_valid_q && !meta_out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_ONE;
         end
      end
   end

   // Control flops. Reset empties the buffer and holds ready low while asserted.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Data registers carry no reset.
   // Their contents are only observed while valid is high.
   always_ff @(posedge aclk) begin
      main_q <= main_d;
      skid_q <= skid_d;
   end

   // Statistics counter flops.
   always_ff @(posedge aclk) begin
      if (areset) begin
         xfer_q  <= '0;
         stall_q <= '0;
      end else begin
         xfer_q  <= xfer_d;
         stall_q <= stall_d;
      end
   end

   assign meta_in_ready  = in_ready_q;
   assign meta_out_valid = out_valid_q;
   assign meta_out_data  = main_q;
   assign occupancy      = state_q;
   assign xfer_cnt       = xfer_q;
   assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_axis_meta_skid.sv
// Testbench for axis_meta_skid.
// The reference model is a word queue plus plain counters.
// Every cycle, the DUT's handshakes, data, occupancy and statistics are compared against it.
module tb_axis_meta_skid;

   localparam int WIDTH   = 56;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = 255;

   logic             aclk = 1'b0;
   logic             areset;
   logic             meta_in_valid;
   logic             meta_in_ready;
   logic [WIDTH-1:0] meta_in_data;
   logic             meta_out_valid;
   logic             meta_out_ready;
   logic [WIDTH-1:0] meta_out_data;
   logic             clear_stats;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] xfer_cnt;
   logic [CNT_W-1:0] stall_cnt;

   int               n_compared   = 0;
   int               n_mismatched = 0;

   logic [WIDTH-1:0] model_q[$];
   int               exp_xfer  = 0;
   int               exp_stall = 0;
   logic             exp_ready = 1'b0;
   int               accepted  = 0;
   int               delivered = 0;

   axis_meta_skid #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .aclk           (aclk),
      .areset         (areset),
      .meta_in_valid  (meta_in_valid),
      .meta_in_ready  (meta_in_ready),
      .meta_in_data   (meta_in_data),
      .meta_out_valid (meta_out_valid),
      .meta_out_ready (meta_out_ready),
      .meta_out_data  (meta_out_data),
      .clear_stats    (clear_stats),
      .occupancy      (occupancy),
      .xfer_cnt       (xfer_cnt),
      .stall_cnt      (stall_cnt)
   );

   // Free-running clock.
   always #5 aclk = ~aclk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, advances the model across the clock edge,
   // then compares all outputs shortly after the edge.
   task automatic applyStimulus(input logic rst, input logic vin, input logic [WIDTH-1:0] din,
                                input logic rdy, input logic clr);
      logic             exp_valid_pre;
      logic             do_in;
      logic             do_out;
      logic             stalled;
      logic [WIDTH-1:0] hold_word;
      areset         = rst;
      meta_in_valid  = vin;
      meta_in_data   = din;
      meta_out_ready = rdy;
      clear_stats    = clr;
      exp_valid_pre  = (model_q.size() > 0);
      do_in          = vin && exp_ready;
      do_out         = exp_valid_pre && rdy;
      stalled        = exp_valid_pre && !rdy && !rst;
      hold_word      = exp_valid_pre ? model_q[0] : '0;
      @(posedge aclk);
      if (rst) begin
         model_q.delete();
         exp_xfer  = 0;
         exp_stall = 0;
         exp_ready = 1'b0;
      end else begin
         if (do_out) begin
            void'(model_q.pop_front());
            delivered++;
         end
         if (do_in) begin
            model_q.push_back(din);
            accepted++;
         end
         if (clr) begin
            exp_xfer  = 0;
            exp_stall = 0;
         end else begin
            if (do_out) exp_xfer = (exp_xfer + 1) % (CNT_MAX + 1);
            if (exp_valid_pre && !rdy && exp_stall < CNT_MAX) exp_stall++;
         end
         exp_ready = (model_q.size() < 2);
      end
      #1;
      checkOutput("in_ready", 64'(meta_in_ready), 64'(exp_ready));
      checkOutput("out_valid", 64'(meta_out_valid), 64'(model_q.size() > 0));
      checkOutput("occupancy", 64'(occupancy), 64'(model_q.size()));
      checkOutput("xfer_cnt", 64'(xfer_cnt), 64'(exp_xfer));
      checkOutput("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      if (model_q.size() > 0) checkOutput("out_data", 64'(meta_out_data), 64'(model_q[0]));
      if (stalled) checkOutput("stall_hold", 64'(meta_out_data), 64'(hold_word));
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [63:0] r;
      logic        vin;
      logic        rdy;
      logic        clr;
      areset         = 1'b1;
      meta_in_valid  = 1'b0;
      meta_in_data   = '0;
      meta_out_ready = 1'b0;
      clear_stats    = 1'b0;

      // Reset and streaming at full throughput.
      $display("[TB] streaming");
      doReset();
      checkOutput("post_reset_ready", 64'(meta_in_ready), 64'd1);
      delivered = 0;
      for (int i = 1; i <= 16; i++) applyStimulus(1'b0, 1'b1, WIDTH'(i), 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      checkOutput("stream_delivered", 64'(delivered), 64'd16);
      checkOutput("stream_xfer", 64'(xfer_cnt), 64'd16);
      checkOutput("stream_stall", 64'(stall_cnt), 64'd0);

      // Backpressure: fill both entries, then stall.
      $display("[TB] backpressure");
      doReset();
      applyStimulus(1'b0, 1'b1, WIDTH'(32'hA), 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, WIDTH'(32'hB), 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, WIDTH'(32'hC), 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, WIDTH'(32'hD), 1'b0, 1'b0);
      checkOutput("bp_occ", 64'(occupancy), 64'd2);
      checkOutput("bp_ready", 64'(meta_in_ready), 64'd0);
      checkOutput("bp_data", 64'(meta_out_data), 64'hA);
      checkOutput("bp_stall", 64'(stall_cnt), 64'd3);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      checkOutput("bp_second", 64'(meta_out_data), 64'hB);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      checkOutput("bp_drained", 64'(meta_out_valid), 64'd0);

      // Reset while full discards both words.
      $display("[TB] reset in full");
      doReset();
      applyStimulus(1'b0, 1'b1, WIDTH'(32'h11), 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, WIDTH'(32'h22), 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
      checkOutput("rst_full_valid", 64'(meta_out_valid), 64'd0);
      checkOutput("rst_full_occ", 64'(occupancy), 64'd0);
      checkOutput("rst_full_xfer", 64'(xfer_cnt), 64'd0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      checkOutput("rst_full_quiet", 64'(meta_out_valid), 64'd0);

      // Counter wrap, saturation and clear precedence.
      $display("[TB] counters");
      doReset();
      for (int i = 0; i < 256; i++) applyStimulus(1'b0, 1'b1, WIDTH'(i + 100), 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      checkOutput("xfer_wrap", 64'(xfer_cnt), 64'd0);
      applyStimulus(1'b0, 1'b1, WIDTH'(32'h55), 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("stall_sat", 64'(stall_cnt), 64'hFF);
      applyStimulus(1'b0, 1'b1, WIDTH'(32'h66), 1'b1, 1'b1);
      checkOutput("clr_xfer", 64'(xfer_cnt), 64'd0);
      checkOutput("clr_stall", 64'(stall_cnt), 64'd0);
      checkOutput("clr_keeps_data", 64'(meta_out_data), 64'h66);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);

      // Random traffic: 50% valid, 50% ready, occasional clear.
      $display("[TB] random");
      doReset();
      accepted  = 0;
      delivered = 0;
      for (int c = 0; c < 60000 && delivered < 10000; c++) begin
         r   = {$urandom(), $urandom()};
         vin = (accepted < 10000) && ($urandom_range(0, 1) == 1);
         rdy = ($urandom_range(0, 1) == 1);
         clr = ($urandom_range(0, 63) == 0);
         applyStimulus(1'b0, vin, r[WIDTH-1:0], rdy, clr);
      end
      checkOutput("rand_delivered", 64'(delivered), 64'd10000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/axis_meta_skid.md
AXIS_META_SKID -- requirements
Module: axis_meta_skid

Interface
REQ-001 Parameter: WIDTH, default 32, bit width of meta data; legal range 1..512.
REQ-002 Parameter: CNT_W, default 32, width of the statistics counters; legal range 8..64.
REQ-003 Port: aclk  input  1  single clock; all logic is on the rising edge.
REQ-004 Port: areset  input  1  synchronous, active-high reset.
REQ-005 Port: meta_in  axis_meta.slave  valid/ready/data[WIDTH]  upstream meta stream.
REQ-006 Port: meta_out  axis_meta.master  valid/ready/data[WIDTH]  downstream meta stream.
REQ-007 Port: clear_stats  input  1  synchronous clear of the statistics counters only.
REQ-008 Port: occupancy  output  2  number of buffered words (0..2).
REQ-009 Port: xfer_cnt  output  CNT_W  count of completed meta_out transfers; wraps modulo 2^CNT_W.
REQ-010 Port: stall_cnt  output  CNT_W  cycles with meta_out.valid=1 and meta_out.ready=0; saturates at all-ones.

Function
REQ-011 Block SHALL be a 2-entry skid buffer; meta_in.ready and meta_out.valid/data SHALL come directly from flops, with no combinational path from input to output.
REQ-012 Storage SHALL consist of a main register (drives meta_out.data) and a skid register.
REQ-013 FSM states SHALL be EMPTY (occ 0), BUSY (occ 1, main valid), and FULL (occ 2, main+skid valid).
REQ-014 meta_in.ready SHALL be 1 in EMPTY and BUSY, and 0 in FULL.
REQ-015 meta_out.valid SHALL be 1 in BUSY and FULL, and 0 in EMPTY.
REQ-016 In = meta_in.valid & meta_in.ready; out = meta_out.valid & meta_out.ready.
REQ-017 EMPTY transitions:
- On in: main<=data, go to BUSY.
- Otherwise: stay in EMPTY.
REQ-018 BUSY transitions:
- On in & out: main<=data, stay in BUSY.
- On in & !out: skid<=data, go to FULL.
- On !in & out: go to EMPTY.
- On !in & !out: hold.
REQ-019 FULL transitions:
- On out: main<=skid, go to BUSY.
- Otherwise: hold; the input is not accepted because ready=0.
REQ-020 Latency SHALL be 1 cycle from the in-handshake to meta_out.valid when EMPTY.
REQ-021 Sustained throughput SHALL be 1 word/cycle when meta_out.ready is held at 1.
REQ-022 Ordering SHALL be strict FIFO, with no loss and no duplication.
REQ-023 meta_out.data SHALL be stable while meta_out.valid=1 and meta_out.ready=0.
REQ-024 occupancy SHALL equal the state encoding (EMPTY=0, BUSY=1, FULL=2); value 3 is never produced.
REQ-025 xfer_cnt SHALL increment by 1 on each out; all-ones+1 -> 0.
REQ-026 stall_cnt SHALL increment when meta_out.valid & !meta_out.ready, and hold at all-ones.
REQ-027 When clear_stats and an increment coincide, clear SHALL take precedence; both counters read 0 next cycle.
REQ-028 clear_stats SHALL NOT affect the FSM, the data registers, or the handshakes.
REQ-029 Data register contents in EMPTY are don't-care, but SHALL NOT be X-propagated onto meta_out.valid.

Reset
REQ-030 While areset=1 at a clock edge, state SHALL go to EMPTY, meta_out.valid=0, occupancy=0, xfer_cnt=0, and stall_cnt=0.
REQ-031 During reset, meta_in.ready SHALL be 0; it SHALL be 1 in the first cycle after areset deasserts.
REQ-032 Reset asserted mid-operation (BUSY/FULL) SHALL discard buffered words; no output transfer completes on the reset edge.
REQ-033 Main and skid data registers SHALL NOT require reset.

Verification
REQ-034 Streaming: ready=1, inputs 0x1..0x10 back-to-back -> outputs 0x1..0x10 on consecutive cycles starting 1 cycle later; xfer_cnt=16; stall_cnt=0.
REQ-035 Backpressure: push 0xA, 0xB with ready=0 -> occupancy=2, meta_in.ready=0, meta_out.data=0xA held; after 3 stalled cycles stall_cnt=3 (counting from first valid); release ready -> 0xA then 0xB.
REQ-036 Simultaneous in & out in BUSY -> occupancy stays 1, and the output sequence is preserved.
REQ-037 Reset in FULL -> next cycle meta_out.valid=0 and occupancy=0; neither buffered word ever appears.
REQ-038 Counters: preload scenario with CNT_W=8 and 256 transfers -> xfer_cnt=0; 300 stall cycles -> stall_cnt=0xFF; clear_stats with a simultaneous transfer -> both 0.
REQ-039 Random: random valid/ready at 50% each, 10k words, WIDTH=56 -> scoreboard matches in order, and meta_out.data never changes while stalled.
